dma_modport: RTL and testbench
==============================

Name: dma_modport

Overview:
- DMA controller register block: single-port register file with write and read access over a simple bus (addr, wdata, wr_en, rdata).
- Holds DMA programming registers plus a minimal transfer-progress model: busy/done, transfer count, interrupt status, alignment error.
- Sits behind the DMA bus interface; its driver side writes, its monitor side samples rdata.

Parameters:
- DATA_WIDTH, 32, register/data bus width (`data_width).
- ADDR_WIDTH, 32, byte address width (`addr_width).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  1 = write cycle, 0 = read cycle.
- addr  input  ADDR_WIDTH  byte address of the register.
- wdata  input  DATA_WIDTH  write data.
- rdata  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset (rst=0, async): every register and rdata = 0; engine state IDLE.
- Write: at posedge with wr_en=1, the addressed RW field takes wdata. RO fields ignore writes. Unmapped addresses ignore writes. rdata holds its value.
- Read: at posedge with wr_en=0, rdata <= addressed register (1-cycle latency). Unmapped addresses read 0.
- Register map (all registers reset to 0):
  - 0x400 INTR: [15:0] intr_status, RO. [31:16] intr_mask, RW.
  - 0x404 CTRL: [0] start_dma, RW, self-clearing. [15:1] w_count, RW. [16] io_mem, RW. [31:17] reserved, read 0.
  - 0x408 IO_ADDR: RW, 32 bits.
  - 0x40C MEM_ADDR: RW, 32 bits.
  - 0x410 EXTRA_INFO: RW, 32 bits.
  - 0x414 STATUS: RO. [0] busy, [1] done, [2] error, [3] paused (always 0), [7:4] current_state, [15:8] fifo_level (always 0).
  - 0x418 TRANSFER_COUNT: RO, 32 bits.
  - 0x41C DESCRIPTOR_ADDR: RW, 32 bits.
  - 0x420 ERROR_STATUS:
    - [0] bus_error, W1C.
    - [1] timeout_error, W1C.
    - [2] alignment_error, W1C.
    - [3] overflow, W1C.
    - [4] underflow, W1C.
    - [15:8] error_code, RO.
    - [31:16] error_addr_offset, RO.
  - 0x424 CONFIG:
    - [1:0] priority, RW.
    - [2] auto_restart, RW.
    - [3] interrupt_enable, RW.
    - [5:4] burst_size, RW.
    - [7:6] data_width, RW.
    - [8] descriptor_mode, RW.
    - remaining bits read 0.
- Engine FSM: IDLE(0), BUSY(1), DONE(2), ERROR(3); current_state mirrors the state.
  - IDLE or DONE to BUSY: a CTRL write with start_dma=1, and io_addr[1:0] and mem_addr[1:0] both 0.
    - Sets busy=1, done=0 and TRANSFER_COUNT=0.
  - Alignment failure: a start write with either address not 4-byte aligned goes to ERROR.
    - Sets alignment_error=1, error=1, error_code=0x02 and error_addr_offset = io_addr[15:0].
  - BUSY: TRANSFER_COUNT increments by 1 per cycle. When it equals w_count, go to DONE.
    - On DONE: busy=0, done=1, start_dma cleared, intr_status[0]=1.
    - w_count=0 completes on the cycle after start.
  - DONE with auto_restart=1: restarts the transfer on the next cycle.
  - ERROR to IDLE: when ERROR_STATUS[4:0] has been cleared to 0 via W1C. error then clears.
  - CTRL write with start_dma=1 while BUSY: ignored (fields unchanged).
- Simultaneous events: a register write and an engine update in the same cycle → the engine update wins for RO fields. W1C wins over error set only if set is not asserted that cycle.
- Reset mid-transfer: everything returns to 0 and IDLE immediately.

Decomposition:
- Package dma_reg_pkg holds:
  - Register address localparams (0x400–0x424).
  - FSM state enum.
  - Field bit-position constants.
- Optional sub-module dma_modport_engine: FSM, TRANSFER_COUNT and status/error generation. Register decode and read mux stay at top.

Test Plan:
- Reset → read every register, including 0x428 (unmapped) → all rdata=0.
- Write 0xA5A5_A5A4 to IO_ADDR, then read → rdata=0xA5A5_A5A4 one cycle after the read sample. Same RW walk for MEM_ADDR, EXTRA_INFO, DESCRIPTOR_ADDR and CONFIG (CONFIG reads 0x1FF after writing 0xFFFF_FFFF).
- Write 0xFFFF_FFFF to STATUS and TRANSFER_COUNT → both still read 0.
- IO_ADDR=0x1000, MEM_ADDR=0x2000, CTRL=0x0000_0009 (w_count=4, start=1) → STATUS busy=1 and state=1 within 4 cycles. Then STATUS = 0x0000_0022 (done=1, state=2), TRANSFER_COUNT=4, INTR=0x0000_0001, CTRL[0]=0.
- IO_ADDR=0x1002, start → STATUS error=1 with state=3, ERROR_STATUS=0x1002_0204. Write 0x4 to ERROR_STATUS → error bits clear, state returns to IDLE.
- Assert rst during BUSY → all registers read 0 after release.

Source files
------------

// File: rtl/dma_reg_pkg.sv
// Shared definitions for the DMA register block: register map, engine states, field positions.
package dma_reg_pkg;

    localparam int unsigned REG_W     = 32;
    localparam int unsigned MAP_AW    = 12;
    localparam int unsigned WCOUNT_W  = 15;
    localparam int unsigned ERR_W     = 5;
    localparam int unsigned CFG_W     = 9;

    localparam logic [MAP_AW-1:0] ADDR_INTR       = 12'h400;
    localparam logic [MAP_AW-1:0] ADDR_CTRL       = 12'h404;
    localparam logic [MAP_AW-1:0] ADDR_IO_ADDR    = 12'h408;
    localparam logic [MAP_AW-1:0] ADDR_MEM_ADDR   = 12'h40C;
    localparam logic [MAP_AW-1:0] ADDR_EXTRA_INFO = 12'h410;
    localparam logic [MAP_AW-1:0] ADDR_STATUS     = 12'h414;
    localparam logic [MAP_AW-1:0] ADDR_XFER_COUNT = 12'h418;
    localparam logic [MAP_AW-1:0] ADDR_DESC_ADDR  = 12'h41C;
    localparam logic [MAP_AW-1:0] ADDR_ERR_STATUS = 12'h420;
    localparam logic [MAP_AW-1:0] ADDR_CONFIG     = 12'h424;

    localparam int unsigned CTRL_START_BIT       = 0;
    localparam int unsigned CTRL_IO_MEM_BIT      = 16;
    localparam int unsigned ERR_ALIGN_BIT        = 2;
    localparam int unsigned CFG_AUTO_RESTART_BIT = 2;

    localparam logic [7:0] ERR_CODE_ALIGN = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } dma_state_e;

endpackage

// File: rtl/dma_modport_engine.sv
// Transfer-progress engine: state machine, transfer counter, start bit, error and interrupt status.
module dma_modport_engine
    import dma_reg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_req,
    input  logic [15:0]         io_addr_lo,
    input  logic [1:0]          mem_addr_lo,
    input  logic [WCOUNT_W-1:0] w_count,
    input  logic                auto_restart,
    input  logic [ERR_W-1:0]    err_w1c,
    output dma_state_e          state,
    output logic                start_dma,
    output logic [REG_W-1:0]    transfer_count,
    output logic [ERR_W-1:0]    err_flags,
    output logic [7:0]          error_code,
    output logic [15:0]         error_addr_offset,
    output logic                done_intr
);

    dma_state_e         state_nxt;
    logic               start_nxt;
    logic [REG_W-1:0]   count_nxt;
    logic [ERR_W-1:0]   err_nxt;
    logic [7:0]         code_nxt;
    logic [15:0]        offset_nxt;
    logic               intr_nxt;
    logic               launch;
    logic               aligned;

    assign aligned = (io_addr_lo[1:0] == 2'b00) && (mem_addr_lo == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            start_dma         <= 1'b0;
            transfer_count    <= '0;
            err_flags         <= '0;
            error_code        <= '0;
            error_addr_offset <= '0;
            done_intr         <= 1'b0;
        end else begin
            state             <= state_nxt;
            start_dma         <= start_nxt;
            transfer_count    <= count_nxt;
            err_flags         <= err_nxt;
            error_code        <= code_nxt;
            error_addr_offset <= offset_nxt;
            done_intr         <= intr_nxt;
        end
    end

    // W1C is applied first so a same-cycle error set overrides the clear.
    always_comb begin
        state_nxt  = state;
        start_nxt  = start_dma;
        count_nxt  = transfer_count;
        err_nxt    = err_flags & ~err_w1c;
        code_nxt   = error_code;
        offset_nxt = error_addr_offset;
        intr_nxt   = done_intr;
        launch     = 1'b0;

        case (state)
            ST_IDLE:  launch = start_req;
            ST_BUSY: begin
                if (transfer_count == REG_W'(w_count)) begin
                    state_nxt = ST_DONE;
                    start_nxt = 1'b0;
                    intr_nxt  = 1'b1;
                end else begin
                    count_nxt = transfer_count + REG_W'(1);
                end
            end
            ST_DONE:  launch = start_req || auto_restart;
            ST_ERROR: begin
                if (err_nxt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase

        if (launch) begin
            if (aligned) begin
                state_nxt = ST_BUSY;
                start_nxt = 1'b1;
                count_nxt = '0;
            end else begin
                state_nxt              = ST_ERROR;
                start_nxt              = 1'b0;
                err_nxt[ERR_ALIGN_BIT] = 1'b1;
                code_nxt               = ERR_CODE_ALIGN;
                offset_nxt             = io_addr_lo;
            end
        end
    end

endmodule

// File: rtl/dma_modport.sv
// DMA register block: bus decode, programming registers, registered read mux around the engine.
module dma_modport
    import dma_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [REG_W-1:0]    wd;
    logic [REG_W-1:0]    rd_val;
    logic [15:0]         intr_mask;
    logic [WCOUNT_W-1:0] w_count;
    logic                io_mem;
    logic [REG_W-1:0]    io_addr;
    logic [REG_W-1:0]    mem_addr;
    logic [REG_W-1:0]    extra_info;
    logic [REG_W-1:0]    desc_addr;
    logic [CFG_W-1:0]    cfg;

    dma_state_e          state;
    logic                start_dma;
    logic [REG_W-1:0]    transfer_count;
    logic [ERR_W-1:0]    err_flags;
    logic [7:0]          error_code;
    logic [15:0]         error_addr_offset;
    logic                done_intr;
    logic                start_req_c;
    logic [ERR_W-1:0]    err_w1c_c;

    assign wd = REG_W'(wdata);

    function automatic logic hit(input logic [ADDR_WIDTH-1:0] a, input logic [MAP_AW-1:0] reg_addr);
        return a == ADDR_WIDTH'(reg_addr);
    endfunction

    assign start_req_c = wr_en && hit(addr, ADDR_CTRL) && wd[CTRL_START_BIT];
    assign err_w1c_c   = (wr_en && hit(addr, ADDR_ERR_STATUS)) ? wd[ERR_W-1:0] : '0;

    dma_modport_engine u_engine (
        .clk               (clk),
        .rst               (rst),
        .start_req         (start_req_c),
        .io_addr_lo        (io_addr[15:0]),
        .mem_addr_lo       (mem_addr[1:0]),
        .w_count           (w_count),
        .auto_restart      (cfg[CFG_AUTO_RESTART_BIT]),
        .err_w1c           (err_w1c_c),
        .state             (state),
        .start_dma         (start_dma),
        .transfer_count    (transfer_count),
        .err_flags         (err_flags),
        .error_code        (error_code),
        .error_addr_offset (error_addr_offset),
        .done_intr         (done_intr)
    );

    // RW register writes; a start write during a transfer leaves CTRL untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            intr_mask  <= '0;
            w_count    <= '0;
            io_mem     <= 1'b0;
            io_addr    <= '0;
            mem_addr   <= '0;
            extra_info <= '0;
            desc_addr  <= '0;
            cfg        <= '0;
        end else if (wr_en) begin
            if (hit(addr, ADDR_INTR))       intr_mask  <= wd[31:16];
            if (hit(addr, ADDR_CTRL) && !(state == ST_BUSY && wd[CTRL_START_BIT])) begin
                w_count <= wd[WCOUNT_W:1];
                io_mem  <= wd[CTRL_IO_MEM_BIT];
            end
            if (hit(addr, ADDR_IO_ADDR))    io_addr    <= wd;
            if (hit(addr, ADDR_MEM_ADDR))   mem_addr   <= wd;
            if (hit(addr, ADDR_EXTRA_INFO)) extra_info <= wd;
            if (hit(addr, ADDR_DESC_ADDR))  desc_addr  <= wd;
            if (hit(addr, ADDR_CONFIG))     cfg        <= wd[CFG_W-1:0];
        end
    end

    always_comb begin
        rd_val = '0;
        if (hit(addr, ADDR_INTR))       rd_val = {intr_mask, 15'd0, done_intr};
        if (hit(addr, ADDR_CTRL))       rd_val = {15'd0, io_mem, w_count, start_dma};
        if (hit(addr, ADDR_IO_ADDR))    rd_val = io_addr;
        if (hit(addr, ADDR_MEM_ADDR))   rd_val = mem_addr;
        if (hit(addr, ADDR_EXTRA_INFO)) rd_val = extra_info;
        if (hit(addr, ADDR_STATUS))     rd_val = {16'd0, 8'd0, 4'(state), 1'b0,
                                                  state == ST_ERROR, state == ST_DONE, state == ST_BUSY};
        if (hit(addr, ADDR_XFER_COUNT)) rd_val = transfer_count;
        if (hit(addr, ADDR_DESC_ADDR))  rd_val = desc_addr;
        if (hit(addr, ADDR_ERR_STATUS)) rd_val = {error_addr_offset, error_code, 3'd0, err_flags};
        if (hit(addr, ADDR_CONFIG))     rd_val = {23'd0, cfg};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (!wr_en) begin
            rdata <= DATA_WIDTH'(rd_val);
        end
    end

endmodule

// File: tb/tb_dma_modport.sv
// Directed bench for dma_modport: expected read data is queued at issue and checked on return.
module tb_dma_modport;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    localparam logic [31:0] A_INTR   = 32'h400;
    localparam logic [31:0] A_CTRL   = 32'h404;
    localparam logic [31:0] A_IO     = 32'h408;
    localparam logic [31:0] A_MEM    = 32'h40C;
    localparam logic [31:0] A_EXTRA  = 32'h410;
    localparam logic [31:0] A_STATUS = 32'h414;
    localparam logic [31:0] A_TC     = 32'h418;
    localparam logic [31:0] A_DESC   = 32'h41C;
    localparam logic [31:0] A_ERR    = 32'h420;
    localparam logic [31:0] A_CFG    = 32'h424;
    localparam logic [31:0] A_UNMAP  = 32'h428;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        logic [31:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dma_modport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic [31:0] mask, input string tag);
        exp_t e;
        @(negedge clk);
        wr_en = 1'b0;
        addr  = a;
        sb.push_back('{tag, exp, mask});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.tag, rdata & e.mask, e.exp & e.mask);
    endtask

    // Repeated reads until the masked value appears; a missed budget counts as a failure.
    task automatic poll(input logic [31:0] a, input logic [31:0] val, input logic [31:0] mask,
                        input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            addr  = a;
            @(posedge clk);
            #1;
            if ((rdata & mask) == val) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++)
            rd(A_INTR + 32'(4 * i), 32'h0, 32'hFFFF_FFFF, $sformatf("reset_rd_%h", A_INTR + 32'(4 * i)));

        wr(A_IO, 32'hA5A5_A5A4);
        rd(A_IO, 32'hA5A5_A5A4, 32'hFFFF_FFFF, "io_addr_rw");
        wr(A_MEM, 32'hA5A5_A5A4);
        check("rdata_hold_on_write", rdata, 32'hA5A5_A5A4);
        rd(A_MEM, 32'hA5A5_A5A4, 32'hFFFF_FFFF, "mem_addr_rw");
        wr(A_EXTRA, 32'h5A5A_5A5B);
        rd(A_EXTRA, 32'h5A5A_5A5B, 32'hFFFF_FFFF, "extra_info_rw");
        wr(A_DESC, 32'hA5A5_A5A4);
        rd(A_DESC, 32'hA5A5_A5A4, 32'hFFFF_FFFF, "desc_addr_rw");
        wr(A_CFG, 32'hFFFF_FFFF);
        rd(A_CFG, 32'h0000_01FF, 32'hFFFF_FFFF, "config_rw");
        wr(A_CFG, 32'h0);
        wr(A_INTR, 32'hFFFF_FFFF);
        rd(A_INTR, 32'hFFFF_0000, 32'hFFFF_FFFF, "intr_mask_rw");
        wr(A_INTR, 32'h0);
        wr(A_CTRL, 32'hFFFF_FFFE);
        rd(A_CTRL, 32'h0001_FFFE, 32'hFFFF_FFFF, "ctrl_rw_no_start");
        wr(A_STATUS, 32'hFFFF_FFFF);
        wr(A_TC, 32'hFFFF_FFFF);
        wr(A_ERR, 32'hFFFF_FFFF);
        wr(A_UNMAP, 32'hFFFF_FFFF);
        rd(A_STATUS, 32'h0, 32'hFFFF_FFFF, "status_ro");
        rd(A_TC, 32'h0, 32'hFFFF_FFFF, "tc_ro");
        rd(A_ERR, 32'h0, 32'hFFFF_FFFF, "err_status_ro");
        rd(A_UNMAP, 32'h0, 32'hFFFF_FFFF, "unmapped");

        // Aligned transfer of w_count=4
        wr(A_IO, 32'h1000);
        wr(A_MEM, 32'h2000);
        wr(A_CTRL, 32'h0000_0009);
        poll(A_STATUS, 32'h11, 32'hF1, 4, "busy_seen");
        poll(A_STATUS, 32'h20, 32'hF0, 20, "done_seen");
        rd(A_STATUS, 32'h0000_0022, 32'hFFFF_FFFF, "status_done");
        rd(A_TC, 32'h4, 32'hFFFF_FFFF, "tc_done");
        rd(A_INTR, 32'h0000_0001, 32'hFFFF_FFFF, "intr_done");
        rd(A_CTRL, 32'h0000_0008, 32'hFFFF_FFFF, "ctrl_start_cleared");

        // Zero-length transfer completes the cycle after start
        wr(A_CTRL, 32'h0000_0001);
        rd(A_STATUS, 32'h0000_0011, 32'hFFFF_FFFF, "wcount0_busy");
        rd(A_STATUS, 32'h0000_0022, 32'hFFFF_FFFF, "wcount0_done");
        rd(A_TC, 32'h0, 32'hFFFF_FFFF, "wcount0_tc");

        // Misaligned start raises the alignment error
        wr(A_CTRL, 32'h0000_0008);
        wr(A_IO, 32'h1002);
        wr(A_CTRL, 32'h0000_0009);
        rd(A_STATUS, 32'h0000_0034, 32'hFFFF_FFFF, "status_error");
        rd(A_ERR, 32'h1002_0204, 32'hFFFF_FFFF, "err_status_align");
        rd(A_CTRL, 32'h0000_0008, 32'hFFFF_FFFF, "ctrl_after_error");
        wr(A_ERR, 32'h0000_0001);
        rd(A_ERR, 32'h1002_0204, 32'hFFFF_FFFF, "w1c_other_bit");
        rd(A_STATUS, 32'h0000_0034, 32'hFFFF_FFFF, "still_error");
        wr(A_ERR, 32'h0000_0004);
        rd(A_ERR, 32'h0, 32'h0000_001F, "w1c_cleared");
        rd(A_STATUS, 32'h0, 32'hFFFF_FFFF, "idle_after_clear");

        // Reset in the middle of a long transfer
        wr(A_IO, 32'h1000);
        wr(A_CTRL, 32'h0000_00C9);
        rd(A_STATUS, 32'h0000_0011, 32'hFFFF_FFFF, "long_busy");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rdata_async_reset", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 11; i++)
            rd(A_INTR + 32'(4 * i), 32'h0, 32'hFFFF_FFFF, $sformatf("midreset_rd_%h", A_INTR + 32'(4 * i)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
